// File: rtl/two_bit_mult_pkg.sv
// Shared widths and types for the 2x2-bit multiplier cell.
package two_bit_mult_pkg;

  localparam int unsigned OPERAND_W = 2;
  localparam int unsigned PRODUCT_W = 4;
  localparam int unsigned ACC_W     = 8;

  typedef logic [OPERAND_W-1:0] operand_t;
  typedef logic [PRODUCT_W-1:0] product_t;
  typedef logic [ACC_W-1:0]     acc_t;

endpackage : two_bit_mult_pkg

// File: rtl/two_bit_partial_product.sv
// Gate-level 2x2 unsigned multiply: AND array of partial products plus two half adders.
module two_bit_partial_product
  import two_bit_mult_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] result
);

  operand_t a_w;
  operand_t b_w;
  logic     pp00;
  logic     pp10;
  logic     pp01;
  logic     pp11;
  logic     c;

  assign a_w = a;
  assign b_w = b;

  // Partial products a_i * b_j
  assign pp00 = a_w[0] & b_w[0];
  assign pp10 = a_w[1] & b_w[0];
  assign pp01 = a_w[0] & b_w[1];
  assign pp11 = a_w[1] & b_w[1];

  // First half adder sums the two weight-2 terms
  assign c = pp10 & pp01;

  // Second half adder folds the carry into the weight-4 term
  assign result = {pp11 & c, pp11 ^ c, pp10 ^ pp01, pp00};

endmodule : two_bit_partial_product

// File: rtl/two_bit_multiplier.sv
// Leaf 2x2-bit multiplier cell: combinational product, registered copy with valid,
// and an optional 8-bit wrap-around accumulator selected by TWO_BIT_MULT_ACC_EN.
module two_bit_multiplier
  import two_bit_mult_pkg::*;
(
  input  logic       CLK,
  input  logic       rst,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       in_valid,
  output logic [3:0] result,
  output logic [3:0] result_q,
  output logic       out_valid,
  output logic [7:0] acc
);

  product_t product;

  two_bit_partial_product u_pp (
    .a      (a),
    .b      (b),
    .result (product)
  );

  assign result = product;

  // Registered product holds its last accepted value; valid follows in_valid every edge
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      result_q  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid) begin
        result_q <= product;
      end
      out_valid <= in_valid;
    end
  end

`ifdef TWO_BIT_MULT_ACC_EN
  acc_t acc_q;

  // Running sum of accepted products, wrapping modulo 2^ACC_W
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (in_valid) begin
      acc_q <= acc_q + ACC_W'(product);
    end
  end

  assign acc = acc_q;
`else
  assign acc = '0;
`endif

endmodule : two_bit_multiplier

// File: tb/tb_two_bit_multiplier.sv
// Self-checking bench for two_bit_multiplier; accumulator expectations follow TWO_BIT_MULT_ACC_EN.
module tb_two_bit_multiplier;

  logic       CLK;
  logic       rst;
  logic [1:0] a;
  logic [1:0] b;
  logic       in_valid;
  logic [3:0] result;
  logic [3:0] result_q;
  logic       out_valid;
  logic [7:0] acc;

  logic clk_run;
  int   n_tests;
  int   n_fail;

  // Reference model state
  logic [3:0] m_q;
  logic       m_v;
  int         m_sum;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [3];

  two_bit_multiplier dut (
    .CLK       (CLK),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .result    (result),
    .result_q  (result_q),
    .out_valid (out_valid),
    .acc       (acc)
  );

  initial CLK = 1'b0;
  always #5 if (clk_run) CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int prod(input logic [1:0] x, input logic [1:0] y);
    return int'(x) * int'(y);
  endfunction

  function automatic int exp_acc();
`ifdef TWO_BIT_MULT_ACC_EN
    return m_sum % 256;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_q   = 4'd0;
    m_v   = 1'b0;
    m_sum = 0;
  endtask

  // One rising edge as the spec describes it, in plain arithmetic
  task automatic model_edge();
    if (in_valid) begin
      m_q   = 4'(prod(a, b));
      m_sum = (m_sum + prod(a, b)) % 256;
    end
    m_v = in_valid;
  endtask

  task automatic cycle();
    @(posedge CLK);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".result"}, int'(result), prod(a, b));
    check({tag, ".result_q"}, int'(result_q), int'(m_q));
    check({tag, ".out_valid"}, int'(out_valid), int'(m_v));
    check({tag, ".acc"}, int'(acc), exp_acc());
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    clk_run  = 1'b0;
    rst      = 1'b0;
    a        = 2'd0;
    b        = 2'd0;
    in_valid = 1'b0;
    model_reset();

    vecs[0] = '{a: 2'b11, b: 2'b11, exp: 4'b1001};
    vecs[1] = '{a: 2'b01, b: 2'b01, exp: 4'b0001};
    vecs[2] = '{a: 2'b10, b: 2'b01, exp: 4'b0010};

    // Reset applies with no clock at all
    #1 rst = 1'b1;
    #1;
    check("reset.result_q", int'(result_q), 0);
    check("reset.out_valid", int'(out_valid), 0);
    check("reset.acc", int'(acc), 0);

    // Clockless directed vectors
    for (int i = 0; i < 3; i++) begin
      a = vecs[i].a;
      b = vecs[i].b;
      #15;
      check($sformatf("noclk_vec%0d", i), int'(result), int'(vecs[i].exp));
    end

    // Exhaustive combinational sweep
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        a = 2'(i);
        b = 2'(j);
        #1;
        check($sformatf("comb_%0dx%0d", i, j), int'(result), i * j);
      end
    end

    rst = 1'b0;
    #1;
    clk_run = 1'b1;

    // Single accepted sample, then hold
    @(negedge CLK);
    a = 2'd3; b = 2'd2; in_valid = 1'b1;
    cycle();
    check("reg1.result_q", int'(result_q), 6);
    check("reg1.out_valid", int'(out_valid), 1);
    @(negedge CLK);
    in_valid = 1'b0;
    cycle();
    check("reg2.result_q", int'(result_q), 6);
    check("reg2.out_valid", int'(out_valid), 0);
    check_model("reg2");

    // Asynchronous reset between edges
    @(negedge CLK);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst.result_q", int'(result_q), 0);
    check("arst.out_valid", int'(out_valid), 0);
    check("arst.acc", int'(acc), 0);
    check("arst.result", int'(result), 6);
    @(negedge CLK);
    rst = 1'b0;

    // 29 back-to-back 3x3 samples: 261 wraps to 5
    for (int i = 0; i < 29; i++) begin
      @(negedge CLK);
      a = 2'd3; b = 2'd3; in_valid = 1'b1;
      cycle();
    end
`ifdef TWO_BIT_MULT_ACC_EN
    check("acc29", int'(acc), 5);
`else
    check("acc29", int'(acc), 0);
`endif
    check("acc29.result_q", int'(result_q), 9);
    @(negedge CLK);
    in_valid = 1'b0;
    cycle();
    check_model("acc_hold");

    // Reset while a sample is in flight; the first edge after release samples normally
    @(negedge CLK);
    a = 2'd2; b = 2'd2; in_valid = 1'b1;
    #2 rst = 1'b1;
    #1 model_reset();
    @(posedge CLK);
    #1;
    check_model("inflight");
    @(negedge CLK);
    rst = 1'b0;
    a = 2'd1; b = 2'd3; in_valid = 1'b1;
    cycle();
    check("post_rst.result_q", int'(result_q), 3);
    check_model("post_rst");

    // Randomized stimulus against the reference model
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      a        = 2'($urandom_range(0, 3));
      b        = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
      cycle();
      check_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_two_bit_multiplier

// File: doc/two_bit_multiplier.md
# two_bit_multiplier

Unsigned 2×2-bit multiplier producing a 4-bit product. It is the leaf multiplier cell of the SIMD multiplier array. The product is available combinationally, so the cell can be exercised without a clock. A clocked side-channel provides a registered copy of the product with a valid flag, and optionally an accumulator, for pipelined lanes.

## Interface
Parameters:
- none; widths are fixed: operand 2, product 4, accumulator 8.

Ports:
- CLK  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  2  unsigned multiplicand.
- b  input  2  unsigned multiplier.
- in_valid  input  1  qualifies a/b for the registered path.
- result  output  4  combinational product a×b.
- result_q  output  4  registered product.
- out_valid  output  1  registered in_valid.
- acc  output  8  running sum of products; 0 when TWO_BIT_MULT_ACC_EN is undefined.

## Operation
- result = a × b, unsigned, exact; range 0..9, so it never overflows 4 bits.
- Gate form, which is required so that no `*` operator is used:
  - result[0] = a0·b0
  - result[1] = a1·b0 ⊕ a0·b1
  - c = a1·b0 · a0·b1
  - result[2] = a1·b1 ⊕ c
  - result[3] = a1·b1 · c
- result depends only on a and b. It is independent of CLK and rst, and is valid with CLK idle or stuck.
- X/Z on a or b propagates to result; no masking.
- Registered path: on each rising CLK edge,
  - result_q ← result when in_valid = 1, otherwise hold;
  - out_valid ← in_valid.
- Accumulator (macro enabled): on each rising CLK edge with in_valid = 1, acc ← acc + zero-extended result, modulo 256 (wraps; no saturation, no flag). acc holds otherwise.

## Timing
- result: zero-cycle combinational latency.
- result_q and out_valid: 1-cycle latency from the edge that samples in_valid = 1.
- acc: updated at the same edge; includes the new product 1 cycle after sampling.
- Reset values: result_q = 0, out_valid = 0, acc = 0, applied immediately on rst assertion regardless of CLK.
- Reset mid-stream:
  - Samples in flight are discarded.
  - The first edge after rst deasserts samples normally.
  - result continues tracking a×b during reset.
- in_valid = 1 on consecutive cycles: every cycle is accepted. No backpressure and no stall.

## Configuration
- TWO_BIT_MULT_ACC_EN defined: the 8-bit wrap-around accumulator is built and drives acc.
- TWO_BIT_MULT_ACC_EN undefined: no accumulator register; acc is tied to 8'h00. result, result_q and out_valid are unchanged.

## Structure
- Package two_bit_mult_pkg:
  - OPERAND_W = 2, PRODUCT_W = 4, ACC_W = 8;
  - typedefs operand_t, product_t, acc_t.
- Sub-module two_bit_partial_product: pure combinational AND array plus two half adders implementing the gate form above. Ports a, b, result.
- The top level instantiates two_bit_partial_product and adds the registered path and the optional accumulator.

## Test plan
- With no clock running: a=2'b11, b=2'b11 -> result=4'b1001; a=01, b=01 -> 4'b0001; a=10, b=01 -> 4'b0010. Each is checked 15 time units after it is applied.
- Exhaustive 16 operand pairs, combinational -> result equals a×b for every pair, max 9. Cases a=0 or b=0 -> 0.
- Registered path: a=3, b=2, in_valid=1 for one edge -> next cycle result_q=6, out_valid=1. The following edge with in_valid=0 -> out_valid=0, result_q holds 6.
- Asynchronous reset: assert rst between edges while result_q=6 -> result_q=0, out_valid=0, acc=0 at once; result still shows a×b.
- Accumulator (TWO_BIT_MULT_ACC_EN): 29 consecutive valid cycles of 3×3 -> acc reaches 261 mod 256 = 5. The same bench without the macro -> acc stays 0.
